// File: rtl/conv_pkg.sv
// Shared widths and FSM state for the 7x7 window generator
// and the convolution core downstream of it.
package conv_pkg;

    localparam int CONV_IMA   = 8;
    localparam int CONV_K     = 7;
    localparam int CONV_WIN_W = CONV_IMA * CONV_K * CONV_K;

    typedef enum logic {
        IDLE,
        ACTIVE
    } win_state_t;

endpackage

// File: rtl/conv_window_gen_line_buf_row.sv
// One buffered image row: single-port RAM, asynchronous read and
// synchronous write, so a read returns the old word (read-before-write).
module line_buf_row
    import conv_pkg::*;
#(
    parameter int IMA   = CONV_IMA,
    parameter int DEPTH = 28,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  addr,
    input  logic [IMA-1:0] wr_data,
    output logic [IMA-1:0] rd_data
);

    logic [IMA-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming KxK sliding-window generator: K-1 line buffers feed a
// column-shifting window register, one window per in-frame pixel.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int IMA   = CONV_IMA,
    parameter int K     = CONV_K,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IMA-1:0]     pix_in,
    input  logic               pix_valid,
    input  logic               sof,
    output logic [IMA*K*K-1:0] win_data,
    output logic               win_valid,
    output logic               win_last,
    output logic               frame_err
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(K - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(K - 1);

    win_state_t state, state_nxt;
    logic [CW-1:0] col, col_nxt, pos_col;
    logic [RW-1:0] row, row_nxt, pos_row;
    logic restart, accept, emit, is_last, err_nxt;

    logic [IMA-1:0] lb_rd [K-1];
    logic [IMA-1:0] lb_wr [K-1];
    logic [IMA-1:0] new_col [K];
    logic [IMA-1:0] win [K][K];

    // A sof pixel is always position (0,0), whatever the counters say.
    always_comb begin
        restart   = pix_valid & sof;
        accept    = pix_valid & (restart | (state == ACTIVE));
        pos_col   = restart ? '0 : col;
        pos_row   = restart ? '0 : row;
        emit      = accept & (pos_row >= ROW_MIN) & (pos_col >= COL_MIN);
        is_last   = accept & (pos_row == ROW_LAST) & (pos_col == COL_LAST);
        err_nxt   = restart & (state == ACTIVE) & ((col != '0) | (row != '0));
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        if (accept) begin
            if (is_last) begin
                state_nxt = IDLE;
                col_nxt   = '0;
                row_nxt   = '0;
            end else begin
                state_nxt = ACTIVE;
                if (pos_col == COL_LAST) begin
                    col_nxt = '0;
                    row_nxt = pos_row + RW'(1);
                end else begin
                    col_nxt = pos_col + CW'(1);
                    row_nxt = pos_row;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            col       <= col_nxt;
            row       <= row_nxt;
            win_valid <= emit;
            win_last  <= emit & is_last;
            frame_err <= err_nxt;
        end
    end

    // Row 0 is the oldest buffered line; each write moves a line up one slot.
    for (genvar i = 0; i < K - 1; i++) begin : g_lb
        if (i == K - 2) begin : g_top
            assign lb_wr[i] = pix_in;
        end else begin : g_mid
            assign lb_wr[i] = lb_rd[i+1];
        end
        assign new_col[i] = lb_rd[i];

        line_buf_row #(
            .IMA   (IMA),
            .DEPTH (IMG_W)
        ) u_row (
            .clk     (clk),
            .we      (accept),
            .addr    (pos_col),
            .wr_data (lb_wr[i]),
            .rd_data (lb_rd[i])
        );
    end
    assign new_col[K-1] = pix_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][K-1] <= new_col[r];
            end
        end
    end

    for (genvar r = 0; r < K; r++) begin : g_pr
        for (genvar c = 0; c < K; c++) begin : g_pc
            assign win_data[IMA*(r*K+c) +: IMA] = win[r][c];
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 10x10 frame with K=7,
// pixel value (row*16+col) mod 256.
module tb_conv_window_gen;

    localparam int W  = 10;
    localparam int H  = 10;
    localparam int WW = 8 * 49;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    pix_in;
    logic          pix_valid;
    logic          sof;
    logic [WW-1:0] win_data;
    logic          win_valid;
    logic          win_last;
    logic          frame_err;

    int tests  = 0;
    int failed = 0;
    int nwin;
    int nlast;

    conv_window_gen #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .sof       (sof),
        .win_data  (win_data),
        .win_valid (win_valid),
        .win_last  (win_last),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input int r, input int c);
        return 8'((r * 16 + c) % 256);
    endfunction

    function automatic logic [WW-1:0] exp_win(input int r0, input int c0);
        logic [WW-1:0] w;
        w = '0;
        for (int r = 0; r < 7; r++) begin
            for (int c = 0; c < 7; c++) begin
                w[8*(r*7+c) +: 8] = pix(r0 - 6 + r, c0 - 6 + c);
            end
        end
        return w;
    endfunction

    task automatic drive(input logic v, input logic s, input logic [7:0] p);
        pix_valid = v;
        sof       = s;
        pix_in    = p;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_win(input string tag, input logic [WW-1:0] obs,
                             input logic [WW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives pixels 0..stop-1 of a frame in raster order, sof on the first,
    // checking every output cycle against the window model.
    task automatic frame(input bit gap, input bit err_first, input int stop);
        int  r, c;
        bit  ev, el;
        for (int i = 0; i < stop; i++) begin
            r  = i / W;
            c  = i % W;
            ev = (r >= 6) && (c >= 6);
            el = ev && (r == H - 1) && (c == W - 1);
            drive(1'b1, i == 0, pix(r, c));
            check("win_valid", win_valid, ev);
            check("win_last", win_last, el);
            check("frame_err", frame_err, err_first && (i == 0));
            if (ev) begin
                nwin++;
                if (el) nlast++;
                check_win("win_data", win_data, exp_win(r, c));
            end
            if (gap) begin
                drive(1'b0, 1'b0, 8'($urandom));
                check("gap_valid", win_valid, 0);
                check("gap_last", win_last, 0);
                if (ev) check_win("gap_hold", win_data, exp_win(r, c));
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        pix_valid = 1'b0;
        sof       = 1'b0;
        pix_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        check_win("rst_data", win_data, '0);
        check("rst_valid", win_valid, 0);
        check("rst_last", win_last, 0);
        check("rst_err", frame_err, 0);
        rst = 1'b0;

        // Full frame, continuous pixels, with explicit corner elements.
        nwin = 0;
        nlast = 0;
        for (int i = 0; i < W * H; i++) begin
            drive(1'b1, i == 0, pix(i / W, i % W));
            if (i == 6 * W + 6) begin
                check("first_valid", win_valid, 1);
                check("first_e0", win_data[7:0], 8'h00);
                check("first_e48", win_data[WW-1 -: 8], 8'h66);
            end
            if (i == W * H - 1) begin
                check("last_flag", win_last, 1);
                check("last_e0", win_data[7:0], 8'h33);
                check("last_e48", win_data[WW-1 -: 8], 8'h99);
            end
            if (win_valid) nwin++;
        end
        check("s1_count", nwin, 16);

        // Same frame with pix_valid toggling.
        nwin = 0;
        nlast = 0;
        frame(1'b1, 1'b0, W * H);
        check("s2_count", nwin, 16);
        check("s2_last", nlast, 1);

        // Pixels before any sof are dropped.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 8'($urandom));
            check("presof_valid", win_valid, 0);
        end
        nwin = 0;
        nlast = 0;
        frame(1'b0, 1'b0, W * H);
        check("s3_count", nwin, 16);
        check("s3_last", nlast, 1);

        // Early sof at (3,4) restarts the frame and flags an error once.
        nwin = 0;
        nlast = 0;
        frame(1'b0, 1'b0, 3 * W + 4);
        frame(1'b0, 1'b1, W * H);
        check("s4_count", nwin, 16);
        check("s4_last", nlast, 1);

        // Reset at pixel (8,2), then stray pixels, then a clean frame.
        nwin = 0;
        frame(1'b0, 1'b0, 8 * W + 2);
        check("s5_pre_count", nwin, 8);
        rst = 1'b1;
        drive(1'b1, 1'b0, pix(8, 2));
        check_win("s5_rst_data", win_data, '0);
        check("s5_rst_valid", win_valid, 0);
        check("s5_rst_last", win_last, 0);
        check("s5_rst_err", frame_err, 0);
        rst = 1'b0;
        for (int i = 8 * W + 3; i < W * H; i++) begin
            drive(1'b1, 1'b0, pix(i / W, i % W));
            check("s5_ign_valid", win_valid, 0);
        end
        nwin = 0;
        nlast = 0;
        frame(1'b0, 1'b0, W * H);
        check("s5_count", nwin, 16);
        check("s5_last", nlast, 1);

        // Two frames back to back.
        nwin = 0;
        nlast = 0;
        frame(1'b0, 1'b0, W * H);
        frame(1'b0, 1'b0, W * H);
        check("s6_count", nwin, 32);
        check("s6_last", nlast, 2);

        drive(1'b0, 1'b0, 8'h00);
        check("tail_valid", win_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 7x7 sliding-window generator that sits directly upstream of the 7x7 convolution core. It accepts a raster-order 8-bit pixel stream, buffers the previous K-1 image rows, and emits one fully populated KxK window per accepted pixel once the window lies entirely inside the frame. Each window drives the core's packed image bus (`ima`). `win_valid` drives the core's `enable`. Stride 1, no padding, no backpressure; the convolution core accepts a window every cycle.

## Interface
- `IMA`, 8: pixel width in bits
- `K`, 7: window edge; window holds K*K = 49 pixels
- `IMG_W`, 28: frame width in pixels (≥ K)
- `IMG_H`, 28: frame height in pixels (≥ K)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `pix_in`  in  IMA  pixel, unsigned
- `pix_valid`  in  1  pixel strobe; one pixel accepted per high cycle
- `sof`  in  1  start of frame; qualified by `pix_valid`, marks pixel (0,0)
- `win_data`  out  IMA*K*K  packed window, registered
- `win_valid`  out  1  `win_data` valid this cycle; connects to core `enable`
- `win_last`  out  1  high with the final window of a frame
- `frame_err`  out  1  one-cycle pulse: `sof` arrived before the current frame completed

## Operation
- FSM states:
  - IDLE (reset state): pixels without `sof` are dropped. `pix_valid & sof` → ACTIVE; that pixel is accepted as (0,0).
  - ACTIVE: every `pix_valid` pixel is accepted.
    - Column counter `col` runs 0..IMG_W-1. Row counter `row` increments when `col` wraps.
    - Acceptance of pixel (IMG_H-1, IMG_W-1) → IDLE.
- `sof` while ACTIVE:
  - If it is not on pixel (0,0) of the expected position, pulse `frame_err`.
  - Restart the counters at (0,0) with that pixel accepted as (0,0).
  - Stay in ACTIVE.
- Line buffer: K-1 rows × IMG_W pixels, addressed by `col`. On each accepted pixel:
  - read column `col` of all K-1 rows;
  - shift the column (rows oldest→newest, then `pix_in`) into the KxK window register, moving columns left;
  - write the shifted column back to the line buffer.
- Line buffer contents are never cleared. Validity is governed only by the counters.
- Window element (r,c) occupies bits [IMA*(r*K+c)+IMA-1 : IMA*(r*K+c)], where:
  - r = 0 is the top (oldest) row;
  - c = 0 is the leftmost (oldest) column;
  - element K*K-1 is the pixel just accepted.
- A window is emitted for accepted pixel (row,col) iff row ≥ K-1 and col ≥ K-1. This gives (IMG_W-K+1)*(IMG_H-K+1) windows per frame.
- `win_last` is set for the window of pixel (IMG_H-1, IMG_W-1).
- Pixel values pass through unmodified; no arithmetic is performed on them.

## Timing
- Latency: window is output 1 cycle after the accepting cycle. `win_data`, `win_valid` and `win_last` are registered together.
- `pix_valid` low:
  - counters, window register and line buffer hold;
  - next cycle `win_valid`=0;
  - `win_data` holds its last value.
- Back-to-back pixels with `pix_valid` held high give consecutive windows on consecutive cycles, with no bubbles within the valid region of a row.
- `frame_err` is registered and asserted in the same cycle as the first window-stage output of the restarted pixel.
- Reset values:
  - `win_data`=0, `win_valid`=0, `win_last`=0, `frame_err`=0;
  - FSM=IDLE, `col`=`row`=0.
- Reset mid-frame aborts the frame immediately. No window is emitted until a new `sof`.
- Line buffer RAM need not be reset.

## Structure
- Shared package `conv_pkg`:
  - `IMA`, `K` defaults;
  - window-width constant (IMA*K*K);
  - FSM state typedef (IDLE, ACTIVE).
  - The convolution core uses the same width constants.
- One sub-module, `line_buf_row`:
  - single-port, read-before-write, IMG_W × IMA;
  - instantiated K-1 times and chained by data, sharing address `col`.

## Test plan
Benches use IMG_W=IMG_H=10, K=7, and pixel value = (row*16+col) mod 256.
- Full frame, `pix_valid` constant 1, `sof` on the first pixel:
  - first `win_valid` the cycle after pixel (6,6) is accepted, with element 0 = 0x00 and element 48 = 0x66;
  - exactly 16 windows total;
  - the last window has `win_last`=1, element 0 = 0x33 and element 48 = 0x99.
- Same frame with `pix_valid` toggling 1/0 every cycle:
  - identical 16 window contents;
  - `win_valid` never high on two consecutive cycles.
- 20 pixels driven before the first `sof`: all dropped, no `win_valid`; the frame then behaves exactly as in the first scenario.
- `sof` asserted at pixel (3,4) of frame 1:
  - `frame_err` pulses once;
  - the subsequent full frame yields the correct 16 windows.
- `rst` asserted mid-frame at pixel (8,2):
  - all outputs 0 next edge;
  - following pixels ignored until `sof`;
  - then a correct frame.
- Two frames back to back with no gap: 32 windows, `win_last` twice, `frame_err` never.
